cache_fill_ctrl: RTL and testbench
==================================

// Module: cache_fill_ctrl
// PURPOSE
//  Miss-refill controller upstream of the 2-way I-cache data/tag arrays.
//  On a cache miss it latches the block-aligned miss address, issues BLOCK_WORDS
//  pipelined word reads to main memory and steers each returned word into the
//  data array. With the final word it raises the tag write that validates the block.
//  Sits between the cache hit/miss logic and the multi-cycle memory model.
// PARAMETERS
//  ADDR_W       16  byte-address width
//  BLOCK_WORDS  8   words per cache block; power of 2
//  WORD_BYTES   2   bytes per word; address step between words
// PORTS
//  clk                input   1       system clock, rising edge
//  rst_n              input   1       asynchronous, active-low reset
//  miss_detected      input   1       cache miss this cycle; upstream gates it with ~fsm_busy
//  miss_address       input   ADDR_W  byte address that missed
//  memory_data_valid  input   1       memory returns one read word this cycle
//  fsm_busy           output  1       refill in progress; cache indexes by fill_address
//  mem_enable         output  1       issue one memory read at memory_address
//  memory_address     output  ADDR_W  read request address
//  fill_address       output  ADDR_W  address of the word being written (index/offset source)
//  write_data_array   output  1       write the returned word into the victim way
//  write_tag_array    output  1       write tag+valid for the victim way (last word only)
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset clears state to IDLE, base to 0 and all counters.
//  - Reset drives every output to 0, including memory_address and fill_address.
//  - Registers: state {IDLE,FILL}; base[ADDR_W]; issue_cnt[log2(BW)+1]; recv_cnt[log2(BW)].
//  - IDLE: all outputs 0. If miss_detected=1 on an edge:
//      base <= {miss_address[ADDR_W-1:OFS], OFS'b0}, where OFS=log2(BW*WORD_BYTES);
//      issue_cnt <= 0; recv_cnt <= 0; state <= FILL.
//  - FILL: fsm_busy=1.
//  - Requests: mem_enable = (issue_cnt < BW).
//      memory_address = base + issue_cnt*WORD_BYTES.
//      issue_cnt increments on each issue, so one request per cycle for BW consecutive cycles.
//      The first request goes out the cycle after the miss.
//      After issue_cnt reaches BW, mem_enable=0 and memory_address holds the last request.
//  - Response accepted when memory_data_valid=1 and recv_cnt < issue_cnt. On acceptance:
//      write_data_array=1 (combinational, same cycle as valid);
//      fill_address = base + recv_cnt*WORD_BYTES; recv_cnt increments.
//    Outside a write, fill_address = base + recv_cnt*WORD_BYTES.
//  - Last word (accepted with recv_cnt == BW-1):
//      write_data_array=1 and write_tag_array=1 in the same cycle; state <= IDLE.
//      fsm_busy falls the next cycle.
//  - Address arithmetic is a modulo-2^ADDR_W add on offset bits only.
//    base is block-aligned, so the index/tag bits never carry.
//  - Boundary conditions:
//    - miss_detected while in FILL: ignored; base is unchanged.
//    - memory_data_valid in IDLE, or with recv_cnt >= issue_cnt: ignored; no write strobe.
//    - A new miss in the same cycle as the last-word write is not possible (upstream gating).
//      Any miss in the first IDLE cycle after the last-word write starts a new fill.
//    - Back-to-back misses: IDLE lasts at least 1 cycle between fills.
//    - rst_n low mid-fill: immediate IDLE with all outputs 0.
//      The tag is never written, so the partial block stays invalid.
//  - Fill latency with fixed memory latency L: BW+L cycles from the miss edge to the tag write.
// TESTING
//  1 Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; state IDLE.
//  2 Basic fill, L=4 memory, miss 0x1236 at cycle 0 ->
//      mem_enable on cycles 1..8, addresses 0x1230..0x123E step 2;
//      write_data_array on cycles 5..12, fill_address 0x1230..0x123E;
//      write_tag_array only on cycle 12; fsm_busy high on cycles 1..12.
//  3 Miss ignored while busy: pulse miss 0xBEEF at cycle 3 of a 0x1230 fill ->
//      base stays 0x1230; exactly 8 requests and 8 writes.
//  4 Spurious valid: data_valid in IDLE, and data_valid before the first issue ->
//      no write_data_array; recv_cnt stays 0.
//  5 Abort: rst_n low at cycle 7 of a fill, re-miss on 0x4440 ->
//      fresh 8-word fill from 0x4440; write_tag_array is never raised for the aborted block.
//  6 Wrap: miss 0xFFFE -> requests 0xFFF0..0xFFFE with no carry;
//      back-to-back misses spaced by exactly one IDLE cycle both complete.

Source files
------------

// File: rtl/cache_fill_ctrl_if.sv
// Refill-controller bus: cache hit/miss logic and memory model on one side,
// the refill controller on the other.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_enable;
  logic [ADDR_W-1:0] memory_address;
  logic [ADDR_W-1:0] fill_address;
  logic              write_data_array;
  logic              write_tag_array;

  // cache/memory side
  modport master (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, mem_enable, memory_address, fill_address,
           write_data_array, write_tag_array
  );

  // refill controller side
  modport slave (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, mem_enable, memory_address, fill_address,
           write_data_array, write_tag_array
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// I-cache miss refill controller: latches the block-aligned miss address,
// streams BLOCK_WORDS pipelined word reads to memory, steers each returned
// word into the data array and validates the tag with the final word.
// BLOCK_WORDS must be a power of 2 and at least 2.
module cache_fill_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_ctrl_if.slave bus
);
  localparam int CW  = $clog2(BLOCK_WORDS);
  localparam int OFS = $clog2(BLOCK_WORDS * WORD_BYTES);
  localparam logic [CW:0]   BW_C   = (CW+1)'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_C = CW'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW:0]       issue_q, issue_d;   // one extra bit so "all issued" is representable
  logic [CW-1:0]     recv_q, recv_d;

  logic              busy, en, wr_data, wr_tag;
  logic [ADDR_W-1:0] mem_addr, fill_addr;
  logic [CW-1:0]     req_idx;
  logic [OFS-1:0]    req_ofs, fill_ofs;

  // Once every request is out, keep presenting the last request address.
  assign req_idx  = (issue_q < BW_C) ? issue_q[CW-1:0] : LAST_C;
  // base is block aligned, so word addresses only ever touch the offset bits
  assign req_ofs  = OFS'(req_idx * WORD_BYTES);
  assign fill_ofs = OFS'(recv_q * WORD_BYTES);

  // State, base and counters; reset abandons any partial fill untagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  // Next state and strobes: issue one read per cycle, accept only responses
  // that match an outstanding request, finish on the last accepted word.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    issue_d   = issue_q;
    recv_d    = recv_q;
    busy      = 1'b0;
    en        = 1'b0;
    wr_data   = 1'b0;
    wr_tag    = 1'b0;
    mem_addr  = '0;
    fill_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          base_d  = {bus.miss_address[ADDR_W-1:OFS], {OFS{1'b0}}};
          issue_d = '0;
          recv_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        busy      = 1'b1;
        en        = (issue_q < BW_C);
        mem_addr  = {base_q[ADDR_W-1:OFS], req_ofs};
        fill_addr = {base_q[ADDR_W-1:OFS], fill_ofs};
        if (en) issue_d = issue_q + 1'b1;
        if (bus.memory_data_valid && ({1'b0, recv_q} < issue_q)) begin
          wr_data = 1'b1;
          recv_d  = recv_q + 1'b1;
          if (recv_q == LAST_C) begin
            wr_tag  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fsm_busy         = busy;
  assign bus.mem_enable       = en;
  assign bus.memory_address   = mem_addr;
  assign bus.fill_address     = fill_addr;
  assign bus.write_data_array = wr_data;
  assign bus.write_tag_array  = wr_tag;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl. A miss accepted by the reference
// model queues the expected request and write events (cycle, address, tag)
// computed from block arithmetic and memory latency; a negedge monitor pops
// and compares them whenever the DUT shows a request or a write.
module tb_cache_fill_ctrl;
  localparam int AW = 16, BW = 8, WB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(AW)) bus ();
  cache_fill_ctrl #(.ADDR_W(AW), .BLOCK_WORDS(BW), .WORD_BYTES(WB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int cyc; logic [AW-1:0] addr; logic tag; } ev_t;
  ev_t exp_req[$];
  ev_t exp_wr[$];
  int  ret_q[$];          // cycles at which the memory returns a word

  int cyc = 0;
  int f_start = -100, f_end = -100, cur_L = 4, wr_done = 0;
  logic [AW-1:0] f_base = '0;
  int n_chk = 0, n_pass = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endfunction

  function automatic bit busy_at(int c);
    return (c >= f_start) && (c <= f_end);
  endfunction

  // Reference model: a miss seen while idle opens a fill of BW words starting
  // next cycle; request k at start+k, its word lands L cycles later.
  task automatic model_miss(logic [AW-1:0] a, int L);
    ev_t e;
    if (busy_at(cyc)) return;
    f_base  = a & ~AW'(BW*WB - 1);
    f_start = cyc + 1;
    f_end   = cyc + BW + L;
    cur_L   = L;
    for (int k = 0; k < BW; k++) begin
      e.cyc = cyc + 1 + k;     e.addr = f_base + AW'(k*WB); e.tag = 1'b0;
      exp_req.push_back(e);
      e.cyc = cyc + 1 + k + L; e.tag  = (k == BW-1);
      exp_wr.push_back(e);
    end
  endtask

  // One clock cycle of stimulus plus the memory model.
  task automatic cycle(bit miss, logic [AW-1:0] a, bit spur, int L);
    bit due, sp, m;
    @(posedge clk); #1; cyc++;
    due = (ret_q.size() > 0) && (ret_q[0] == cyc);
    if (due) void'(ret_q.pop_front());
    // spurious valid only where nothing can be outstanding
    sp = spur && !due && (!busy_at(cyc) || cyc == f_start);
    m  = miss && (cyc != f_end);
    bus.miss_detected     = m;
    bus.miss_address      = a;
    bus.memory_data_valid = due || sp;
    if (m && rst_n) model_miss(a, L);
    @(negedge clk);
    if (rst_n && bus.mem_enable) ret_q.push_back(cyc + cur_L);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_req.size() > 0 || exp_wr.size() > 0 || busy_at(cyc+1)) && n < 100) begin
      cycle(1'b0, '0, 1'b0, 4);
      n++;
    end
    chk("drain_timeout", 64'(n >= 100), 64'd0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"},  64'(bus.fsm_busy), 64'd0);
    chk({tag, "_men"},   64'(bus.mem_enable), 64'd0);
    chk({tag, "_maddr"}, 64'(bus.memory_address), 64'd0);
    chk({tag, "_faddr"}, 64'(bus.fill_address), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.write_data_array), 64'd0);
    chk({tag, "_wtag"},  64'(bus.write_tag_array), 64'd0);
  endtask

  // Monitor: compare every cycle against the scoreboard.
  ev_t me;
  bit  mb, m_en, m_w;
  always @(negedge clk) begin
    if (rst_n) begin
      mb = busy_at(cyc);
      if (cyc == f_start) wr_done = 0;
      chk("fsm_busy", 64'(bus.fsm_busy), 64'(mb));
      if (!mb) begin
        chk("idle_outputs", 64'({bus.mem_enable, bus.write_data_array, bus.write_tag_array,
            bus.memory_address, bus.fill_address}), 64'd0);
      end else begin
        m_en = (exp_req.size() > 0) && (exp_req[0].cyc == cyc);
        chk("mem_enable", 64'(bus.mem_enable), 64'(m_en));
        if (m_en) begin
          me = exp_req.pop_front();
          chk("memory_address", 64'(bus.memory_address), 64'(me.addr));
        end else if (cyc >= f_start + BW) begin
          chk("memory_address_hold", 64'(bus.memory_address), 64'(f_base + AW'((BW-1)*WB)));
        end
        m_w = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
        chk("write_data_array", 64'(bus.write_data_array), 64'(m_w));
        if (m_w) begin
          me = exp_wr.pop_front();
          chk("write_tag_array", 64'(bus.write_tag_array), 64'(me.tag));
          chk("fill_address", 64'(bus.fill_address), 64'(me.addr));
          wr_done++;
        end else begin
          chk("write_tag_array", 64'(bus.write_tag_array), 64'd0);
          chk("fill_address_idle", 64'(bus.fill_address), 64'(f_base + AW'(wr_done*WB)));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.miss_detected = 1'b0;
    bus.miss_address = '0;
    bus.memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // basic fill, L=4, unaligned miss address
    cycle(1'b1, 16'h1236, 1'b0, 4);
    drain();

    // miss while busy is ignored
    cycle(1'b1, 16'h1230, 1'b0, 4);
    cycle(1'b0, '0, 1'b0, 4);
    cycle(1'b0, '0, 1'b0, 4);
    cycle(1'b1, 16'hBEEF, 1'b0, 4);
    drain();

    // spurious valid in IDLE and before the first issue
    cycle(1'b0, '0, 1'b1, 4);
    cycle(1'b1, 16'h2468, 1'b0, 5);
    cycle(1'b0, '0, 1'b1, 4);
    drain();

    // abort mid-fill with asynchronous reset, then refill
    cycle(1'b1, 16'h4448, 1'b0, 3);
    repeat (6) cycle(1'b0, '0, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    exp_req.delete(); exp_wr.delete(); ret_q.delete();
    f_start = -100; f_end = -100;
    repeat (2) cycle(1'b0, '0, 1'b0, 3);
    #2 rst_n = 1'b1;
    cycle(1'b1, 16'h4440, 1'b0, 3);
    drain();

    // wrap at top of address space, then back-to-back miss after one IDLE cycle
    cycle(1'b1, 16'hFFFE, 1'b0, 2);
    while (busy_at(cyc+1)) cycle(1'b0, '0, 1'b0, 2);
    cycle(1'b1, 16'h0A0C, 1'b0, 3);
    drain();

    // randomized traffic
    repeat (600)
      cycle(($urandom % 6) == 0, AW'($urandom), ($urandom % 4) == 0, int'($urandom_range(1, 6)));
    drain();

    chk("exp_req_empty", 64'(exp_req.size()), 64'd0);
    chk("exp_wr_empty", 64'(exp_wr.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
